memory_access_unit32: RTL and testbench
=======================================

# memory_access_unit32

Load/store initiator between the core's memory-request path and the 32-bit memory model's read and write ports. It accepts one byte, half-word or word request at a time and aligns the address down to a word boundary. Loads are served with a word read followed by extraction and sign or zero extension. Sub-word stores are served with read-modify-write, because the memory only accepts whole-word writes.

## Interface
Parameters:
- READ_WAIT, default 1: cycles the read address is held before read data is captured; legal range 1–15.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RESET  in  1  asynchronous, active-high reset.
- in_req_valid  in  1  request present.
- out_req_ready  out  1  unit can accept a request; high only in IDLE.
- in_req_write  in  1  1 = store, 0 = load.
- in_req_size  in  2  0 = byte, 1 = half-word, 2 = word, 3 = illegal.
- in_req_unsigned  in  1  zero-extend loads.
- in_req_address  in  32  byte address.
- in_req_wdata  in  32  store data, right-justified.
- out_resp_valid  out  1  one-cycle completion pulse.
- out_resp_rdata  out  32  load result; 0 for stores and exceptions.
- out_resp_exception  out  1  qualified by out_resp_valid.
- out_mem_read_address  out  32  word-aligned read address.
- in_mem_read_data  in  32  little-endian word from memory.
- in_mem_read_exception  in  1  memory read fault.
- out_mem_write_enable  out  1  word write strobe.
- out_mem_write_address  out  32  word-aligned write address.
- out_mem_write_data  out  32  merged word.
- in_mem_write_exception  in  1  memory write fault.

## Operation
- States: IDLE, READ, WRITE, RESP.
- Accept: a request is accepted when in_req_valid && out_req_ready.
  - All request fields are registered on accept.
  - Word address = address & ~3; byte offset off = address[1:0].
- Misalignment check on accept: size 3, half-word with off[0]=1, or word with off≠0.
  - Goes IDLE→RESP with exception=1.
  - No memory access is made.
- Load: IDLE→READ.
  - READ holds out_mem_read_address for READ_WAIT cycles, counted by a 4-bit counter.
  - In the last READ cycle the unit captures in_mem_read_data and in_mem_read_exception, then goes to RESP.
  - rdata = word >> (8·off), truncated to the size, then sign-extended (unsigned=0) or zero-extended.
- Word store: IDLE→WRITE directly. Write data = wdata.
- Sub-word store: IDLE→READ→WRITE.
  - Merge replaces bytes [off .. off+bytes−1] of the captured word with the low bytes of wdata.
  - If a read exception is captured, the unit skips WRITE and goes READ→RESP with exception=1.
- WRITE: out_mem_write_enable=1 for exactly one cycle, with address and data stable. in_mem_write_exception is sampled in that cycle. Next state is RESP.
- RESP: out_resp_valid=1 for one cycle, then IDLE. A new request cannot be accepted in the RESP cycle.
- out_mem_read_address holds its last value outside READ/WRITE.
- out_mem_write_enable is 0 in every state except WRITE.

## Timing
- Accept at cycle T. With READ_WAIT=W:
  - Load: out_resp_valid at T+W+1.
  - Sub-word store: write at T+W+1, response at T+W+2.
  - Word store: write at T+1, response at T+2.
  - Misaligned: response at T+1.
- Throughput: one request per (latency+1) cycles. IDLE is entered in the cycle after RESP.
- Reset value of every output is 0, including out_req_ready. State returns to IDLE and the counter clears.
- RESET mid-transaction:
  - Outputs clear immediately (asynchronously). out_mem_write_enable drops in the same cycle.
  - The pending response is dropped.
  - out_req_ready rises in the first cycle after RESET deasserts.
- Memory inputs are ignored outside the cycles where they are sampled.

## Configuration
- MEMACC_TRACE_EN
  - Defined: on each RESP cycle, prints one `$write` line with "[MemAccess]", load/store, size, address, rdata or wdata, and the exception flag.
  - Undefined: no trace code is compiled.
  - Cycle behaviour and outputs are identical either way.

## Test plan
- Word at 0x80000100 = 0x8899AABB:
  - Load byte signed at 0x80000103 → resp at T+2, rdata 0xFFFFFF88.
  - Same access unsigned → 0x00000088.
- Store byte 0x5A at 0x80000101 over 0x8899AABB → write enable at T+2 only, address 0x80000100, data 0x88995ABB; resp at T+3 with exception=0.
- Store word 0xDEADBEEF at 0x80000104 → no READ state, write at T+1, resp at T+2.
- Load half-word at 0x80000101 → resp_exception=1 at T+1; write enable never asserted; rdata=0.
- Store half-word at 0x80000102 with in_mem_read_exception=1 in the READ cycle → no write enable; resp_exception=1 at T+2.
- RESET asserted during the WRITE cycle of a store byte → write enable and all outputs 0 in the same cycle; no resp_valid; out_req_ready=1 in the first cycle after RESET falls.

Source files
------------

// File: rtl/memory_access_unit32.sv
// memory_access_unit32
//
// Load/store initiator between the core request path and a 32-bit
// word-addressed memory model. One byte, half-word or word request is
// handled at a time. Loads do a word read, then extract and extend the
// addressed bytes. Sub-word stores do read-modify-write, because the memory
// only accepts whole-word writes.
//
// Parameters:
//   READ_WAIT  cycles the read address is held before read data is captured
//              (legal range 1..15)
//
// Ports:
//   CLK, RESET               clock, asynchronous active-high reset
//   in_req_valid/out_req_ready  request handshake (ready only in IDLE)
//   in_req_write             1 = store, 0 = load
//   in_req_size              0 byte, 1 half-word, 2 word, 3 illegal
//   in_req_unsigned          zero-extend loads
//   in_req_address           byte address
//   in_req_wdata             right-justified store data
//   out_resp_valid           one-cycle completion pulse
//   out_resp_rdata           load result (0 for stores and exceptions)
//   out_resp_exception       fault flag, qualified by out_resp_valid
//   out_mem_read_address     word-aligned read address
//   in_mem_read_data         little-endian read word
//   in_mem_read_exception    read fault
//   out_mem_write_enable     one-cycle word write strobe
//   out_mem_write_address    word-aligned write address
//   out_mem_write_data       merged write word
//   in_mem_write_exception   write fault
//
// Configuration macro:
//   MEMACC_TRACE_EN  when defined, prints one trace line per response cycle.
//                    It has no effect on cycle behaviour or outputs.

module memory_access_unit32 #(
  parameter int READ_WAIT = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        in_req_valid,
  output logic        out_req_ready,
  input  logic        in_req_write,
  input  logic [1:0]  in_req_size,
  input  logic        in_req_unsigned,
  input  logic [31:0] in_req_address,
  input  logic [31:0] in_req_wdata,
  output logic        out_resp_valid,
  output logic [31:0] out_resp_rdata,
  output logic        out_resp_exception,
  output logic [31:0] out_mem_read_address,
  input  logic [31:0] in_mem_read_data,
  input  logic        in_mem_read_exception,
  output logic        out_mem_write_enable,
  output logic [31:0] out_mem_write_address,
  output logic [31:0] out_mem_write_data,
  input  logic        in_mem_write_exception
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(READ_WAIT - 1);

  state_t      state;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [1:0]  req_off;
  logic [31:0] req_word_addr;
  logic [31:0] req_wdata;
  logic [3:0]  wait_cnt;

  logic        accept;
  logic        misaligned;
  logic [31:0] aligned_addr;

  // Select the addressed bytes of a read word and extend them to 32 bits.
  function automatic logic [31:0] extract_load(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  off,
                                               input logic        uns);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (size)
      2'd0:    extract_load = uns ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'd1:    extract_load = uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: extract_load = sh;
    endcase
  endfunction

  // Replace the addressed bytes of a read word with the low bytes of the
  // store data; upper store-data bits beyond the access size are ignored.
  function automatic logic [31:0] merge_store(input logic [31:0] word,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  size,
                                              input logic [1:0]  off);
    logic [31:0] mask;
    case (size)
      2'd0:    mask = 32'h0000_00FF;
      2'd1:    mask = 32'h0000_FFFF;
      default: mask = 32'hFFFF_FFFF;
    endcase
    merge_store = (word & ~(mask << {off, 3'b000}))
                | ((wdata & mask) << {off, 3'b000});
  endfunction

  assign accept       = in_req_valid && out_req_ready;
  assign aligned_addr = {in_req_address[31:2], 2'b00};

  // Size 3 is always illegal; half-words need even and words zero offset.
  assign misaligned = (in_req_size == 2'd3)
                   || ((in_req_size == 2'd1) && in_req_address[0])
                   || ((in_req_size == 2'd2) && (in_req_address[1:0] != 2'b00));

  // Control FSM. Every output is a register updated on the transition into
  // the state that owns it, so response and write strobes are glitch-free
  // one-cycle pulses and reset clears them asynchronously.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state                 <= IDLE;
      req_write             <= 1'b0;
      req_size              <= 2'd0;
      req_unsigned          <= 1'b0;
      req_off               <= 2'd0;
      req_word_addr         <= 32'd0;
      req_wdata             <= 32'd0;
      wait_cnt              <= 4'd0;
      out_req_ready         <= 1'b0;
      out_resp_valid        <= 1'b0;
      out_resp_rdata        <= 32'd0;
      out_resp_exception    <= 1'b0;
      out_mem_read_address  <= 32'd0;
      out_mem_write_enable  <= 1'b0;
      out_mem_write_address <= 32'd0;
      out_mem_write_data    <= 32'd0;
    end else begin
      out_resp_valid       <= 1'b0;
      out_mem_write_enable <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            req_write          <= in_req_write;
            req_size           <= in_req_size;
            req_unsigned       <= in_req_unsigned;
            req_off            <= in_req_address[1:0];
            req_word_addr      <= aligned_addr;
            req_wdata          <= in_req_wdata;
            out_req_ready      <= 1'b0;
            out_resp_rdata     <= 32'd0;
            out_resp_exception <= 1'b0;
            if (misaligned) begin
              state              <= RESP;
              out_resp_valid     <= 1'b1;
              out_resp_exception <= 1'b1;
            end else if (in_req_write && (in_req_size == 2'd2)) begin
              // Whole-word store needs no read: write straight away.
              state                 <= WRITE;
              out_mem_write_enable  <= 1'b1;
              out_mem_write_address <= aligned_addr;
              out_mem_write_data    <= in_req_wdata;
            end else begin
              state                <= READ;
              wait_cnt             <= 4'd0;
              out_mem_read_address <= aligned_addr;
            end
          end else begin
            // Also raises ready on the first edge after reset releases.
            out_req_ready <= 1'b1;
          end
        end

        READ: begin
          if (wait_cnt == WAIT_LAST) begin
            if (in_mem_read_exception) begin
              // A faulted read aborts both loads and read-modify-write.
              state              <= RESP;
              out_resp_valid     <= 1'b1;
              out_resp_exception <= 1'b1;
              out_resp_rdata     <= 32'd0;
            end else if (req_write) begin
              state                 <= WRITE;
              out_mem_write_enable  <= 1'b1;
              out_mem_write_address <= req_word_addr;
              out_mem_write_data    <= merge_store(in_mem_read_data, req_wdata,
                                                   req_size, req_off);
            end else begin
              state              <= RESP;
              out_resp_valid     <= 1'b1;
              out_resp_exception <= 1'b0;
              out_resp_rdata     <= extract_load(in_mem_read_data, req_size,
                                                 req_off, req_unsigned);
            end
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end

        WRITE: begin
          state              <= RESP;
          out_resp_valid     <= 1'b1;
          out_resp_exception <= in_mem_write_exception;
          out_resp_rdata     <= 32'd0;
        end

        RESP: begin
          state              <= IDLE;
          out_req_ready      <= 1'b1;
          out_resp_rdata     <= 32'd0;
          out_resp_exception <= 1'b0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef MEMACC_TRACE_EN
  // One line per completed request, printed in its response cycle.
  always @(posedge CLK) begin
    if (!RESET && (state == RESP)) begin
      $write("[MemAccess] %s size=%0d addr=0x%08h %s=0x%08h exc=%0d\n",
             req_write ? "store" : "load ", req_size,
             req_word_addr | {30'd0, req_off},
             req_write ? "wdata" : "rdata",
             req_write ? req_wdata : out_resp_rdata,
             out_resp_exception);
    end
  end
`else
  // Trace disabled: no trace logic is built.
`endif

endmodule

// File: tb/tb_memory_access_unit32.sv
// Self-checking bench for memory_access_unit32 (READ_WAIT = 1).
// A static memory image answers reads combinationally; a table of directed
// requests with hand-computed results covers loads, stores, misalignment and
// memory faults, followed by hand-written reset sequences.

module tb_memory_access_unit32;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        in_req_valid;
  logic        out_req_ready;
  logic        in_req_write;
  logic [1:0]  in_req_size;
  logic        in_req_unsigned;
  logic [31:0] in_req_address;
  logic [31:0] in_req_wdata;
  logic        out_resp_valid;
  logic [31:0] out_resp_rdata;
  logic        out_resp_exception;
  logic [31:0] out_mem_read_address;
  logic [31:0] in_mem_read_data;
  logic        in_mem_read_exception;
  logic        out_mem_write_enable;
  logic [31:0] out_mem_write_address;
  logic [31:0] out_mem_write_data;
  logic        in_mem_write_exception;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  memory_access_unit32 #(.READ_WAIT(1)) dut (
    .CLK                   (CLK),
    .RESET                 (RESET),
    .in_req_valid          (in_req_valid),
    .out_req_ready         (out_req_ready),
    .in_req_write          (in_req_write),
    .in_req_size           (in_req_size),
    .in_req_unsigned       (in_req_unsigned),
    .in_req_address        (in_req_address),
    .in_req_wdata          (in_req_wdata),
    .out_resp_valid        (out_resp_valid),
    .out_resp_rdata        (out_resp_rdata),
    .out_resp_exception    (out_resp_exception),
    .out_mem_read_address  (out_mem_read_address),
    .in_mem_read_data      (in_mem_read_data),
    .in_mem_read_exception (in_mem_read_exception),
    .out_mem_write_enable  (out_mem_write_enable),
    .out_mem_write_address (out_mem_write_address),
    .out_mem_write_data    (out_mem_write_data),
    .in_mem_write_exception(in_mem_write_exception)
  );

  // Static memory image
  function automatic logic [31:0] memWord(input logic [31:0] a);
    case (a)
      32'h8000_0100: return 32'h8899_AABB;
      32'h8000_0104: return 32'h1122_3344;
      default:       return 32'hCAFE_F00D;
    endcase
  endfunction

  assign in_mem_read_data = memWord(out_mem_read_address);

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rdExc;
    logic        wrExc;
    int          expLat;
    logic [31:0] expRdata;
    logic        expExc;
    int          expWrCycle;
    logic [31:0] expWaddr;
    logic [31:0] expWdata;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs[NVEC];

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Issue one request and measure latency, response and write activity.
  task automatic applyStimulus(input vec_t v, input int idx);
    int          lat;
    int          wrCount;
    int          wrCycle;
    logic [31:0] gotRdata;
    logic [31:0] gotWaddr;
    logic [31:0] gotWdata;
    logic        gotExc;
    logic        readyInResp;
    lat = 0; wrCount = 0; wrCycle = 0;
    gotRdata = '0; gotWaddr = '0; gotWdata = '0; gotExc = 1'b0; readyInResp = 1'b0;
    @(negedge CLK);
    checkOutput($sformatf("v%0d ready", idx), {31'b0, out_req_ready}, 32'd1);
    in_req_write           = v.wr;
    in_req_size            = v.size;
    in_req_unsigned        = v.uns;
    in_req_address         = v.addr;
    in_req_wdata           = v.wdata;
    in_mem_read_exception  = v.rdExc;
    in_mem_write_exception = v.wrExc;
    in_req_valid           = 1'b1;
    @(posedge CLK);
    #1 in_req_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge CLK);
      if (out_mem_write_enable) begin
        wrCount++;
        wrCycle  = k;
        gotWaddr = out_mem_write_address;
        gotWdata = out_mem_write_data;
      end
      if (out_resp_valid) begin
        lat         = k;
        gotRdata    = out_resp_rdata;
        gotExc      = out_resp_exception;
        readyInResp = out_req_ready;
        break;
      end
    end
    checkOutput($sformatf("v%0d latency", idx), 32'(lat), 32'(v.expLat));
    checkOutput($sformatf("v%0d rdata", idx), gotRdata, v.expRdata);
    checkOutput($sformatf("v%0d exception", idx), {31'b0, gotExc}, {31'b0, v.expExc});
    checkOutput($sformatf("v%0d ready_in_resp", idx), {31'b0, readyInResp}, 32'd0);
    checkOutput($sformatf("v%0d write_count", idx), 32'(wrCount),
                (v.expWrCycle != 0) ? 32'd1 : 32'd0);
    if (v.expWrCycle != 0) begin
      checkOutput($sformatf("v%0d write_cycle", idx), 32'(wrCycle), 32'(v.expWrCycle));
      checkOutput($sformatf("v%0d write_addr", idx), gotWaddr, v.expWaddr);
      checkOutput($sformatf("v%0d write_data", idx), gotWdata, v.expWdata);
    end
    in_mem_read_exception  = 1'b0;
    in_mem_write_exception = 1'b0;
  endtask

  initial begin
    logic seen;
    int   respCount;

    //          wr    size  uns   addr          wdata         rdE   wrE  lat rdata         exc  wc waddr         wdata
    vecs[0]  = '{1'b0, 2'd0, 1'b0, 32'h80000103, 32'h00000000, 1'b0, 1'b0, 2, 32'hFFFFFF88, 1'b0, 0, 32'h0, 32'h0};
    vecs[1]  = '{1'b0, 2'd0, 1'b1, 32'h80000103, 32'h00000000, 1'b0, 1'b0, 2, 32'h00000088, 1'b0, 0, 32'h0, 32'h0};
    vecs[2]  = '{1'b0, 2'd1, 1'b0, 32'h80000102, 32'h00000000, 1'b0, 1'b0, 2, 32'hFFFF8899, 1'b0, 0, 32'h0, 32'h0};
    vecs[3]  = '{1'b0, 2'd1, 1'b1, 32'h80000100, 32'h00000000, 1'b0, 1'b0, 2, 32'h0000AABB, 1'b0, 0, 32'h0, 32'h0};
    vecs[4]  = '{1'b0, 2'd2, 1'b0, 32'h80000104, 32'h00000000, 1'b0, 1'b0, 2, 32'h11223344, 1'b0, 0, 32'h0, 32'h0};
    vecs[5]  = '{1'b0, 2'd0, 1'b0, 32'h80000100, 32'h00000000, 1'b0, 1'b0, 2, 32'hFFFFFFBB, 1'b0, 0, 32'h0, 32'h0};
    vecs[6]  = '{1'b0, 2'd0, 1'b0, 32'h80000105, 32'h00000000, 1'b0, 1'b0, 2, 32'h00000033, 1'b0, 0, 32'h0, 32'h0};
    vecs[7]  = '{1'b1, 2'd0, 1'b0, 32'h80000101, 32'h0000005A, 1'b0, 1'b0, 3, 32'h00000000, 1'b0, 2, 32'h80000100, 32'h88995ABB};
    vecs[8]  = '{1'b1, 2'd2, 1'b0, 32'h80000104, 32'hDEADBEEF, 1'b0, 1'b0, 2, 32'h00000000, 1'b0, 1, 32'h80000104, 32'hDEADBEEF};
    vecs[9]  = '{1'b1, 2'd1, 1'b0, 32'h80000106, 32'hABCD1234, 1'b0, 1'b0, 3, 32'h00000000, 1'b0, 2, 32'h80000104, 32'h12343344};
    vecs[10] = '{1'b0, 2'd1, 1'b0, 32'h80000101, 32'h00000000, 1'b0, 1'b0, 1, 32'h00000000, 1'b1, 0, 32'h0, 32'h0};
    vecs[11] = '{1'b0, 2'd2, 1'b0, 32'h80000102, 32'h00000000, 1'b0, 1'b0, 1, 32'h00000000, 1'b1, 0, 32'h0, 32'h0};
    vecs[12] = '{1'b0, 2'd3, 1'b0, 32'h80000100, 32'h00000000, 1'b0, 1'b0, 1, 32'h00000000, 1'b1, 0, 32'h0, 32'h0};
    vecs[13] = '{1'b1, 2'd0, 1'b0, 32'h80000103, 32'hFFFFFF77, 1'b0, 1'b0, 3, 32'h00000000, 1'b0, 2, 32'h80000100, 32'h7799AABB};
    vecs[14] = '{1'b1, 2'd1, 1'b0, 32'h80000102, 32'h00001234, 1'b1, 1'b0, 2, 32'h00000000, 1'b1, 0, 32'h0, 32'h0};
    vecs[15] = '{1'b0, 2'd2, 1'b0, 32'h80000100, 32'h00000000, 1'b1, 1'b0, 2, 32'h00000000, 1'b1, 0, 32'h0, 32'h0};
    vecs[16] = '{1'b1, 2'd2, 1'b0, 32'h80000100, 32'h01020304, 1'b0, 1'b1, 2, 32'h00000000, 1'b1, 1, 32'h80000100, 32'h01020304};

    RESET                  = 1'b0;
    in_req_valid           = 1'b0;
    in_req_write           = 1'b0;
    in_req_size            = 2'd0;
    in_req_unsigned        = 1'b0;
    in_req_address         = 32'd0;
    in_req_wdata           = 32'd0;
    in_mem_read_exception  = 1'b0;
    in_mem_write_exception = 1'b0;
    #2 RESET = 1'b1;

    // Reset state
    repeat (2) @(negedge CLK);
    checkOutput("rst ready", {31'b0, out_req_ready}, 32'd0);
    checkOutput("rst resp_valid", {31'b0, out_resp_valid}, 32'd0);
    checkOutput("rst write_enable", {31'b0, out_mem_write_enable}, 32'd0);
    checkOutput("rst read_address", out_mem_read_address, 32'd0);
    checkOutput("rst rdata", out_resp_rdata, 32'd0);
    RESET = 1'b0;
    @(negedge CLK);
    checkOutput("post-rst ready", {31'b0, out_req_ready}, 32'd1);

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i], i);
    end

    // Reset in the WRITE cycle of a byte store
    @(negedge CLK);
    in_req_write    = 1'b1;
    in_req_size     = 2'd0;
    in_req_unsigned = 1'b0;
    in_req_address  = 32'h8000_0101;
    in_req_wdata    = 32'h0000_005A;
    in_req_valid    = 1'b1;
    @(posedge CLK);
    #1 in_req_valid = 1'b0;
    seen = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge CLK);
      if (out_mem_write_enable) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("rstw write_seen", {31'b0, seen}, 32'd1);
    RESET = 1'b1;
    #1;
    checkOutput("rstw write_enable", {31'b0, out_mem_write_enable}, 32'd0);
    checkOutput("rstw write_data", out_mem_write_data, 32'd0);
    checkOutput("rstw write_address", out_mem_write_address, 32'd0);
    checkOutput("rstw resp_valid", {31'b0, out_resp_valid}, 32'd0);
    checkOutput("rstw ready", {31'b0, out_req_ready}, 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    respCount = 0;
    @(negedge CLK);
    checkOutput("rstw ready_after", {31'b0, out_req_ready}, 32'd1);
    if (out_resp_valid) respCount++;
    repeat (3) begin
      @(negedge CLK);
      if (out_resp_valid) respCount++;
    end
    checkOutput("rstw dropped_resp", 32'(respCount), 32'd0);

    // Recovery after the aborted store
    applyStimulus(vecs[0], 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL timeout actual=running required=finished");
    $fatal(1, "[TB] time limit reached");
  end

endmodule
